// File: rtl/hazard_pkg.sv
// Shared slot entry type and constants for the operand hazard scoreboard.
// Slot fields use the widest supported widths; narrower configurations zero-extend.
package hazard_pkg;

   localparam int RD_MAX_W  = 8;
   localparam int LAT_MAX_W = 4;
   localparam int FWD_RF    = 0;
   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   typedef struct packed {
      logic                 valid;
      logic [RD_MAX_W-1:0]  rd;
      logic [LAT_MAX_W-1:0] lat;
   } slot_t;

   // Forward-select width: value 0 selects the register file, k selects slot k-1.
   function automatic int sel_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue/operand/control bundle between the decode stage and the hazard scoreboard.
// Handshake: issue_valid requests issue; the instruction issues on an edge where stall=0 and freeze=0.
interface hazard_scoreboard_if #(
   parameter int NSRC   = 2,
   parameter int DEPTH  = 3,
   parameter int REG_AW = 5,
   parameter int LAT_W  = 2
);
   localparam int SELW = hazard_pkg::sel_width(DEPTH);

   logic                   issue_valid;
   logic                   issue_regwrite;
   logic [REG_AW-1:0]      issue_rd;
   logic [LAT_W-1:0]       issue_lat;
   logic                   issue_kill;
   logic [NSRC*REG_AW-1:0] src_rs;
   logic [NSRC-1:0]        src_used;
   logic                   freeze;
   logic [DEPTH-1:0]       flush_mask;
   logic [NSRC*SELW-1:0]   fwd_sel;
   logic                   stall;
   logic [15:0]            stall_cnt;

   modport master (
      output issue_valid, issue_regwrite, issue_rd, issue_lat, issue_kill,
      output src_rs, src_used, freeze, flush_mask,
      input  fwd_sel, stall, stall_cnt
   );

   modport slave (
      input  issue_valid, issue_regwrite, issue_rd, issue_lat, issue_kill,
      input  src_rs, src_used, freeze, flush_mask,
      output fwd_sel, stall, stall_cnt
   );

endinterface

// File: rtl/hazard_src_match.sv
// Youngest-first match of one source operand against the in-flight slots.
// Only the youngest matching slot decides: forward from it or request a stall.
module hazard_src_match
   import hazard_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int REG_AW = 5,
   parameter int SELW   = 2
) (
   input  logic                    used_i,
   input  logic [REG_AW-1:0]       rs_i,
   input  slot_t [DEPTH-1:0]       slots_i,
   output logic [SELW-1:0]         sel_o,
   output logic                    stall_o
);

   logic found;

   always_comb begin
      found   = 1'b0;
      sel_o   = SELW'(FWD_RF);
      stall_o = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (!found && used_i && (rs_i != '0) && slots_i[k].valid &&
             (slots_i[k].rd == RD_MAX_W'(rs_i))) begin
            found = 1'b1;
            // A result not yet produced at this stage blocks; older copies are never used.
            if (int'(slots_i[k].lat) <= k) sel_o = SELW'(k + 1);
            else                           stall_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker for EX..EX+DEPTH-1 producing per-operand forward selects,
// an issue stall, and a saturating stall-cycle counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NSRC   = 2,
   parameter int DEPTH  = 3,
   parameter int REG_AW = 5,
   parameter int LAT_W  = 2
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave bus
);

   localparam int SELW = sel_width(DEPTH);

   slot_t [DEPTH-1:0]    slot_q, slot_d, flushed;
   slot_t                new_entry;
   logic [15:0]          cnt_q, cnt_d;
   logic [NSRC-1:0]      op_stall;
   logic [NSRC*SELW-1:0] fwd_sel;
   logic                 stall;
   logic                 accept;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      hazard_src_match #(
         .DEPTH  (DEPTH),
         .REG_AW (REG_AW),
         .SELW   (SELW)
      ) u_match (
         .used_i  (bus.src_used[i]),
         .rs_i    (bus.src_rs[i*REG_AW +: REG_AW]),
         .slots_i (slot_q),
         .sel_o   (fwd_sel[i*SELW +: SELW]),
         .stall_o (op_stall[i])
      );
   end

   // A squashed or idle ID stage never holds the pipe, whatever the operands look like.
   assign stall  = bus.issue_valid && !bus.issue_kill && (|op_stall);
   assign accept = bus.issue_valid && bus.issue_regwrite && !bus.issue_kill &&
                   !stall && (bus.issue_rd != '0);

   always_comb begin
      flushed = slot_q;
      for (int k = 0; k < DEPTH; k++) begin
         if (bus.flush_mask[k]) flushed[k].valid = 1'b0;
      end

      new_entry = '0;
      if (accept) begin
         new_entry.valid = 1'b1;
         new_entry.rd    = RD_MAX_W'(bus.issue_rd);
         new_entry.lat   = LAT_MAX_W'(bus.issue_lat);
      end

      // The oldest slot falls off the end: the register file is write-through.
      slot_d = flushed;
      if (!bus.freeze) begin
         for (int k = 1; k < DEPTH; k++) slot_d[k] = flushed[k-1];
         slot_d[0] = new_entry;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && !bus.freeze && (cnt_q != STALL_CNT_MAX)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
         cnt_q  <= '0;
      end else begin
         slot_q <= slot_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.fwd_sel   = fwd_sel;
   assign bus.stall     = stall;
   assign bus.stall_cnt = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NSRC, default 2: number of source operands checked per issuing instruction.
REQ-002 SHALL have parameter DEPTH, default 3: number of tracked in-flight slots (slot k = stage EX+k).
REQ-003 SHALL have parameter REG_AW, default 5: register address width.
REQ-004 SHALL have parameter LAT_W, default 2: width of the result-latency field.
REQ-005 SHALL have derived constant SELW = clog2(DEPTH+1): forward-select width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 issue_valid  in  1  instruction in ID requests issue.
REQ-009 issue_regwrite  in  1  issuing instruction writes a register.
REQ-010 issue_rd  in  REG_AW  destination of the issuing instruction.
REQ-011 issue_lat  in  LAT_W  first slot index at which the result is forwardable (0 = ALU, 1 = load).
REQ-012 issue_kill  in  1  squash the issuing instruction (branch redirect).
REQ-013 src_rs  in  NSRC*REG_AW  source register addresses, operand i in bits [i*REG_AW +: REG_AW].
REQ-014 src_used  in  NSRC  operand i is actually read.
REQ-015 freeze  in  1  global pipeline hold: no slot shifts.
REQ-016 flush_mask  in  DEPTH  invalidate the selected current slots.
REQ-017 fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = slot k-1.
REQ-018 stall  out  1  issuing instruction must not issue this cycle.
REQ-019 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-020 Each slot SHALL hold valid, rd, lat; x0 destinations and non-writers SHALL never be entered (valid=0).
REQ-021 Operand i SHALL match slot k when src_used[i], valid[k], rd[k]==src_rs[i] and src_rs[i]!=0.
REQ-022 Among matching slots, only the lowest index (youngest) SHALL be considered; older matches are ignored.
REQ-023 If the youngest match k has lat[k] <= k, fwd_sel[i] SHALL be k+1; with no match it SHALL be 0.
REQ-024 If the youngest match k has lat[k] > k, stall SHALL be asserted and fwd_sel[i] SHALL be 0; no older slot is substituted.
REQ-025 stall SHALL be asserted only when issue_valid=1 and issue_kill=0; fwd_sel and stall SHALL be combinational from slot state and inputs.
REQ-026 On an edge with freeze=0: slot[k] <= slot[k-1] for k>=1, and slot[DEPTH-1]'s old entry retires. The register file is write-through, so retired entries need no forwarding.
REQ-027 On the same edge, slot[0] SHALL load {1, issue_rd, issue_lat} only if issue_valid & issue_regwrite & !issue_kill & !stall & issue_rd!=0; otherwise it SHALL load a bubble.
REQ-028 flush_mask[k] SHALL clear the valid bit of current slot k before the shift. A flushed entry therefore moves on as a bubble; with freeze=1 it is cleared in place.
REQ-029 With freeze=1, slots SHALL hold, except for flush_mask clears, and no issue is accepted.
REQ-030 stall_cnt SHALL increment on each edge where stall=1 and freeze=0, saturating at 16'hFFFF.
REQ-031 DEPTH=1 SHALL be legal: only lat=0 entries are forwardable, and all others stall.

Reset
REQ-032 With rst=1 at an edge, all slot valid bits SHALL clear and stall_cnt SHALL become 0. rst overrides freeze, flush and issue.
REQ-033 Out of reset, fwd_sel SHALL be all 0 and stall SHALL be 0.
REQ-034 A rst mid-stall SHALL drop all in-flight entries; no hazard persists afterwards.

Structure
REQ-035 Package hazard_pkg SHALL hold the slot entry struct, SELW computation, and constants FWD_RF=0 and STALL_CNT_MAX.
REQ-036 Per-operand priority matching SHALL be sub-module hazard_src_match, instantiated NSRC times; the slot shift register stays in the top level.

Verification
REQ-037 ALU chain: issue x5 lat0, then read x5 next cycle -> fwd_sel=1, stall=0; one cycle later -> fwd_sel=2.
REQ-038 Load-use: issue x7 lat1, then read x7 next cycle -> stall=1 and stall_cnt +1; next cycle -> fwd_sel=2, stall=0.
REQ-039 Priority: x3 in slot 1 (lat0) and x3 in slot 0 (lat1) -> stall=1 and no forward from slot 1.
REQ-040 x0: issue rd=0, then read x0 -> fwd_sel=0, stall=0, and slot0 valid=0.
REQ-041 Flush and freeze: x9 in slot 0, flush_mask=001 with freeze=1, then read x9 -> fwd_sel=0, and the slots do not shift.
REQ-042 Saturation and reset: hold a stall for 70000 cycles -> stall_cnt=FFFF; then rst -> stall_cnt=0 and all slots empty.
